slc3_mem_ctrl: RTL and testbench
================================

SLC3_MEM_CTRL -- requirements
Module: slc3_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: on-chip RAM word-address width; depth is 2^ADDR_W words of 16 bits.
REQ-002 Parameter INIT_WORDS, default 256: number of program-image words copied from the init ROM, legal range 1..2^ADDR_W.
REQ-003 Clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 Reset  input  1  reset, synchronous and active-low.
REQ-005 ADDR  input  16  CPU word address (the MAR).
REQ-006 Data_to_SRAM  input  16  write data from the memory I/O controller.
REQ-007 OE  input  1  read enable, active-low.
REQ-008 WE  input  1  write enable, active-low.
REQ-009 Reload  input  1  active-high request to re-copy the program image.
REQ-010 Data_from_SRAM  output  16  registered read data to the memory I/O controller.
REQ-011 Ready  output  1  high when the CPU may access memory; the top level gates Run with it.

Function
REQ-012 FSM states: S_INIT (copy image), S_CLEAR (zero the remainder), S_RUN (serve CPU).
REQ-013 S_INIT: each cycle write rom[cnt] to ram[cnt] and increment cnt; after writing cnt==INIT_WORDS-1, go to S_CLEAR, or go to S_RUN if INIT_WORDS==2^ADDR_W.
REQ-014 S_CLEAR: each cycle write 16'h0000 to ram[cnt] and increment cnt; after writing cnt==2^ADDR_W-1, go to S_RUN.
REQ-015 cnt is ADDR_W+1 bits wide, is cleared on entry to S_INIT, and never wraps inside a copy sequence.
REQ-016 A full load takes exactly 2^ADDR_W cycles; Ready rises on the first S_RUN cycle (1024 cycles after Reset deasserts, with defaults).
REQ-017 Ready is low in S_INIT and S_CLEAR. While Ready is low, OE and WE are ignored and Data_from_SRAM is held at 16'h0000.
REQ-018 S_RUN write: if WE is low, then ram[ADDR[ADDR_W-1:0]] is updated with Data_to_SRAM at the clock edge.
REQ-019 S_RUN read: if OE is low and WE is high, then Data_from_SRAM equals ram[ADDR[ADDR_W-1:0]] one cycle later (latency 1).
REQ-020 If OE is high, Data_from_SRAM holds its last value.
REQ-021 If OE and WE are both low, the write occurs and Data_from_SRAM holds its value, so no read-during-write data is returned.
REQ-022 Address bits 15:ADDR_W are ignored, so addresses alias modulo 2^ADDR_W. Exception: any write with ADDR==16'hFFFF (switch/LED I/O) is suppressed, while reads of 16'hFFFF proceed normally.
REQ-023 A Reload input that is high for one or more cycles is detected on its rising edge (one registered stage).
REQ-024 A Reload rising edge in S_RUN causes entry to S_INIT on the next cycle: cnt is cleared, Ready drops, and any CPU access in that cycle is still completed.
REQ-025 A Reload edge during S_INIT or S_CLEAR is ignored and does not restart the copy.
REQ-026 Each copy write goes to exactly one address per cycle; the RAM has a single write port, muxed between the copy path (S_INIT/S_CLEAR) and the CPU path (S_RUN).

Reset
REQ-027 While Reset is low at a clock edge: state becomes S_INIT, cnt becomes 0, Ready becomes 0, Data_from_SRAM becomes 16'h0000, and the Reload edge register is cleared.
REQ-028 Reset asserted mid-copy or mid-run restarts the full load from address 0; RAM contents are not otherwise cleared by reset.
REQ-029 Ready does not assert earlier than 2^ADDR_W cycles after the last cycle with Reset low.

Structure
REQ-030 Package slc3_mem_pkg holds the state enum (S_INIT, S_CLEAR, S_RUN), the default ADDR_W and INIT_WORDS, and the I/O address constant 16'hFFFF.
REQ-031 One sub-module, slc3_init_rom: a combinational lookup from a word index to a 16-bit program word, holding the INIT_WORDS-word image.
REQ-032 The RAM array is inferred inside slc3_mem_ctrl as a synchronous-read block RAM; no other sub-modules.

Verification
REQ-033 Reset low 3 cycles then high: Ready=0 for exactly 1024 cycles, then 1. Check ram[0..255]=ROM image and ram[256..1023]=0.
REQ-034 In S_RUN, write ADDR=16'h0010, data=16'hBEEF, WE low 1 cycle; then read the same address with OE low. Required: Data_from_SRAM=16'hBEEF one cycle after OE goes low.
REQ-035 Write ADDR=16'h0410 with data 16'h1234, then read 16'h0010: returns 16'h1234 (aliasing). Write 16'hFFFF with data 16'hAAAA: ram[1023] is unchanged.
REQ-036 OE and WE both low, ADDR=16'h0020, data=16'h5555: ram[32]=16'h5555 and Data_from_SRAM unchanged. Next cycle OE low only: returns 16'h5555.
REQ-037 Pulse Reload in S_RUN after modifying ram[5]: Ready falls the next cycle, ram[5] returns to its ROM value, and Ready rises 1024 cycles later. A second Reload pulse at cycle 100 of the load has no effect.
REQ-038 Assert Reset at cycle 500 of the initial load: the load restarts, Ready rises 1024 cycles after Reset deasserts, and OE-low reads during the load return 16'h0000.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared definitions for the SLC-3 on-chip memory controller.
//   - state_t          : controller FSM states
//   - DEF_ADDR_W       : default RAM word-address width
//   - DEF_INIT_WORDS   : default program-image length in words
//   - IO_ADDR          : memory-mapped switch/LED address, never written to RAM
package slc3_mem_pkg;

    localparam int unsigned DEF_ADDR_W     = 10;
    localparam int unsigned DEF_INIT_WORDS = 256;
    localparam logic [15:0] IO_ADDR        = 16'hFFFF;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/slc3_init_rom.sv
// Program-image ROM: combinational word lookup.
//   i_idx  : word index into the image
//   o_word : 16-bit program word (0 beyond the image length)
module slc3_init_rom
    import slc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned INIT_WORDS = DEF_INIT_WORDS
) (
    input  logic [ADDR_W-1:0] i_idx,
    output logic [15:0]       o_word
);

    localparam logic [15:0] IMG_SEED = 16'h5000;

    // Image word i is the seed XOR i*257 (i.e. the low index byte repeated).
    always_comb begin
        o_word = 16'h0000;
        if (32'(i_idx) < INIT_WORDS) begin
            o_word = IMG_SEED ^ 16'(32'(i_idx) * 32'd257);
        end
    end

endmodule

// File: rtl/slc3_mem_ctrl.sv
// SLC-3 on-chip memory controller: after reset or Reload, copies the program
// image into RAM, zeroes the rest, then serves CPU reads/writes.
//   Clk            : system clock
//   Reset          : synchronous active-low reset
//   ADDR           : CPU word address (MAR)
//   Data_to_SRAM   : CPU write data
//   OE / WE        : active-low read / write enables
//   Reload         : active-high request to re-copy the image
//   Data_from_SRAM : registered read data (latency 1)
//   Ready          : high when the CPU may access memory
module slc3_mem_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned INIT_WORDS = DEF_INIT_WORDS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_SRAM,
    input  logic        OE,
    input  logic        WE,
    input  logic        Reload,
    output logic [15:0] Data_from_SRAM,
    output logic        Ready
);

    localparam int unsigned DEPTH      = 32'd1 << ADDR_W;
    localparam int unsigned CNT_W      = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(INIT_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);
    localparam bit          INIT_FILLS = (INIT_WORDS == DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_ready;
    logic [15:0]         r_data;
    logic                r_reload_d;
    logic                w_reload_rise;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [15:0]         w_ram_wdata;
    logic [ADDR_W-1:0]   w_cpu_addr;
    logic                w_cpu_rd;
    logic [15:0]         w_rom_word;
    logic [15:0]         r_ram [DEPTH];

    assign w_cpu_addr     = ADDR[ADDR_W-1:0];
    assign w_reload_rise  = Reload & ~r_reload_d;
    assign Data_from_SRAM = r_data;
    assign Ready          = r_ready;

    slc3_init_rom #(
        .ADDR_W     (ADDR_W),
        .INIT_WORDS (INIT_WORDS)
    ) u_rom (
        .i_idx  (r_cnt[ADDR_W-1:0]),
        .o_word (w_rom_word)
    );

    // Next state, copy counter and single RAM write-port mux.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_cnt[ADDR_W-1:0];
        w_ram_wdata = w_rom_word;
        w_cpu_rd    = 1'b0;
        case (r_state)
            S_INIT: begin
                w_ram_we  = 1'b1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_INIT) begin
                    w_state_nxt = INIT_FILLS ? S_RUN : S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = 16'h0000;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_WORD) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_ram_addr  = w_cpu_addr;
                w_ram_wdata = Data_to_SRAM;
                w_ram_we    = ~WE && (ADDR != IO_ADDR);
                w_cpu_rd    = ~OE && WE;
                w_cnt_nxt   = '0;
                if (w_reload_rise) begin
                    w_state_nxt = S_INIT;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // RAM write port; no writes while reset is held.
    always_ff @(posedge Clk) begin
        if (Reset && w_ram_we) begin
            r_ram[w_ram_addr] <= w_ram_wdata;
        end
    end

    // State, counter, Ready and synchronous-read data register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_data     <= 16'h0000;
            r_reload_d <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ready    <= (w_state_nxt == S_RUN);
            r_reload_d <= Reload;
            // Data is forced to zero whenever Ready will be low.
            if (w_state_nxt != S_RUN) begin
                r_data <= 16'h0000;
            end else if (w_cpu_rd) begin
                r_data <= r_ram[w_cpu_addr];
            end
        end
    end

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
module tb_slc3_mem_ctrl;

    logic        Clk;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        OE;
    logic        WE;
    logic        Reload;
    logic [15:0] Data_from_SRAM;
    logic        Ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [1024];
    logic [15:0] m_data;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        oe;
        logic        we;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [12];

    slc3_mem_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .OE             (OE),
        .WE             (WE),
        .Reload         (Reload),
        .Data_from_SRAM (Data_from_SRAM),
        .Ready          (Ready)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Program image: word i (i < 256) is 16'h5000 XOR {i, i}; beyond it, zero.
    function automatic logic [15:0] rom_ref(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i < 256) ? (16'h5000 ^ {b, b}) : 16'h0000;
    endfunction

    task automatic model_load();
        for (int i = 0; i < 1024; i++) mem[i] = rom_ref(i);
        m_data = 16'h0000;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One CPU cycle in S_RUN, applied to the model and checked.
    task automatic op(input logic [15:0] a, input logic [15:0] d, input logic oe, input logic we,
                      input string name);
        logic [9:0] idx;
        ADDR = a; Data_to_SRAM = d; OE = oe; WE = we; Reload = 1'b0;
        @(negedge Clk);
        idx = a[9:0];
        if (!oe && we) m_data = mem[idx];
        if (!we && a != 16'hFFFF) mem[idx] = d;
        check(name, Data_from_SRAM, m_data);
    endtask

    // Run a load with random CPU traffic until Ready or max_c cycles.
    task automatic wait_load(input int pulse_at, input int max_c, output int cycles);
        cycles = 0;
        while (Ready !== 1'b1 && cycles < max_c) begin
            ADDR = 16'($urandom); Data_to_SRAM = 16'($urandom);
            OE = 1'($urandom); WE = 1'($urandom);
            Reload = (cycles == pulse_at);
            @(negedge Clk);
            cycles++;
            if (Ready !== 1'b1) check("load_rd_zero", Data_from_SRAM, 16'h0000);
        end
        Reload = 1'b0; OE = 1'b1; WE = 1'b1;
    endtask

    task automatic dump(input string name);
        for (int i = 0; i < 1024; i++)
            op({6'($urandom), 10'(i)}, 16'($urandom), 1'b0, 1'b1, name);
    endtask

    task automatic random_ops(input int n);
        logic [15:0] a;
        for (int k = 0; k < n; k++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                            : {6'($urandom), 10'($urandom_range(0, 31))};
            op(a, 16'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        int cyc;
        tbl[0]  = '{16'h0010, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
        tbl[1]  = '{16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
        tbl[2]  = '{16'h0410, 16'h1234, 1'b1, 1'b0, 16'hBEEF};
        tbl[3]  = '{16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234};
        tbl[4]  = '{16'hFFFF, 16'hAAAA, 1'b1, 1'b0, 16'h1234};
        tbl[5]  = '{16'h03FF, 16'h0000, 1'b0, 1'b1, 16'h0000};
        tbl[6]  = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000};
        tbl[7]  = '{16'h0020, 16'h5555, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{16'h0020, 16'h0000, 1'b0, 1'b1, 16'h5555};
        tbl[9]  = '{16'h0010, 16'h0000, 1'b1, 1'b1, 16'h5555};
        tbl[10] = '{16'h0005, 16'h7777, 1'b1, 1'b0, 16'h5555};
        tbl[11] = '{16'h0005, 16'h0000, 1'b0, 1'b1, 16'h7777};

        Reset = 1'b0; ADDR = '0; Data_to_SRAM = '0; OE = 1'b1; WE = 1'b1; Reload = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_ready", 16'(Ready), 16'h0000);
        check("rst_data", Data_from_SRAM, 16'h0000);

        // Initial load and full contents.
        Reset = 1'b1;
        wait_load(-1, 2000, cyc);
        check("load_cycles", 16'(cyc), 16'd1024);
        model_load();
        dump("ram_after_load");

        // Directed vectors: write/read, aliasing, I/O address, read-during-write.
        for (int i = 0; i < 12; i++) begin
            op(tbl[i].addr, tbl[i].data, tbl[i].oe, tbl[i].we, "vec_model");
            check($sformatf("vec%0d", i), Data_from_SRAM, tbl[i].exp);
        end

        random_ops(400);

        // Reload in S_RUN with a second pulse at cycle 100 of the load.
        ADDR = 16'h0000; OE = 1'b1; WE = 1'b1; Reload = 1'b1;
        @(negedge Clk);
        check("reload_ready_drop", 16'(Ready), 16'h0000);
        check("reload_data_zero", Data_from_SRAM, 16'h0000);
        wait_load(100, 2000, cyc);
        check("reload_cycles", 16'(cyc), 16'd1024);
        model_load();
        op(16'h0005, 16'h0000, 1'b0, 1'b1, "ram5_restored");
        check("ram5_rom", Data_from_SRAM, rom_ref(5));
        dump("ram_after_reload");

        random_ops(100);

        // Mid-run reset, then reset again at cycle 500 of the load.
        OE = 1'b1; WE = 1'b1;
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("midrun_rst_ready", 16'(Ready), 16'h0000);
        check("midrun_rst_data", Data_from_SRAM, 16'h0000);
        Reset = 1'b1;
        wait_load(-1, 500, cyc);
        check("no_early_ready", 16'(cyc), 16'd500);
        Reset = 1'b0;
        @(negedge Clk);
        check("midload_rst_ready", 16'(Ready), 16'h0000);
        Reset = 1'b1;
        wait_load(-1, 2000, cyc);
        check("restart_cycles", 16'(cyc), 16'd1024);
        model_load();
        dump("ram_after_restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
